// File: rtl/sweep_seq_ctrl.sv
// sweep_seq_ctrl: steps the voltage-ROM address through 0..LAST_ADDR and,
// for every address, sequences DAC write -> settle wait -> ADC conversion ->
// UART transmit using start/done pulse handshakes with the peer blocks.
// Every output is a flop; next-cycle values are decoded from the next state.
module sweep_seq_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int LAST_ADDR  = 309,
  parameter int SETTLE_CYC = 1000,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              dac_start_o,
  input  logic              dac_done_i,
  output logic              adc_start_o,
  input  logic              adc_done_i,
  output logic              tx_start_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DAC_GO,
    S_DAC_WAIT,
    S_SETTLE,
    S_ADC_GO,
    S_ADC_WAIT,
    S_TX_GO,
    S_TX_WAIT,
    S_STEP,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(SETTLE_CYC - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;

  // Next-state, next-address and settle-counter decode; abort overrides everything.
  always_comb begin
    state_nx = state;
    addr_nx  = addr_o;
    cnt_nx   = cnt;
    if (abort_i) begin
      state_nx = S_IDLE;
      addr_nx  = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state_nx = S_DAC_GO;
            addr_nx  = '0;
          end
        end
        S_DAC_GO:   state_nx = S_DAC_WAIT;
        S_DAC_WAIT: begin
          if (dac_done_i) begin
            state_nx = S_SETTLE;
            cnt_nx   = '0;
          end
        end
        S_SETTLE: begin
          // Counter runs 0..SETTLE_CYC-1, so SETTLE lasts exactly SETTLE_CYC cycles.
          if (cnt == CNT_END) state_nx = S_ADC_GO;
          else                cnt_nx   = cnt + CNT_W'(1);
        end
        S_ADC_GO:   state_nx = S_ADC_WAIT;
        S_ADC_WAIT: if (adc_done_i) state_nx = S_TX_GO;
        S_TX_GO:    state_nx = S_TX_WAIT;
        S_TX_WAIT:  if (tx_done_i) state_nx = S_STEP;
        S_STEP: begin
          if (addr_o == ADDR_LAST) begin
            state_nx = S_FIN;
          end else begin
            state_nx = S_DAC_GO;
            addr_nx  = addr_o + ADDR_W'(1);
          end
        end
        S_FIN: begin
          state_nx = S_IDLE;
          addr_nx  = '0;
        end
        default: begin
          state_nx = S_IDLE;
          addr_nx  = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Registered address, settle counter and outputs, decoded from the next state
  // so each pulse lines up with the cycle its state is occupied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_o      <= '0;
      cnt         <= '0;
      dac_start_o <= 1'b0;
      adc_start_o <= 1'b0;
      tx_start_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      addr_o      <= addr_nx;
      cnt         <= cnt_nx;
      dac_start_o <= (state_nx == S_DAC_GO);
      adc_start_o <= (state_nx == S_ADC_GO);
      tx_start_o  <= (state_nx == S_TX_GO);
      busy_o      <= (state_nx != S_IDLE);
      done_o      <= (state_nx == S_FIN);
    end
  end

endmodule

// File: tb/tb_sweep_seq_ctrl.sv
// Bench for sweep_seq_ctrl with a short sweep (LAST_ADDR=3, SETTLE_CYC=4).
// The bench plays the DAC/ADC/TX peers with random reply latencies and random
// stray handshakes, and predicts every output from the transaction timeline:
// start -> dac pulse next cycle, dac_done -> adc pulse SETTLE_CYC+1 cycles on,
// adc_done -> tx pulse next cycle, tx_done -> next address or done pulse two
// cycles on.
module tb_sweep_seq_ctrl;
  localparam int ADDR_W     = 9;
  localparam int LAST_ADDR  = 3;
  localparam int SETTLE_CYC = 4;
  localparam int CNT_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              dac_done = 1'b0;
  logic              adc_done = 1'b0;
  logic              tx_done = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              dac_start;
  logic              adc_start;
  logic              tx_start;
  logic              busy;
  logic              done;

  int n_chk = 0;
  int n_pass = 0;
  int cnt_dac, cnt_adc, cnt_tx, cnt_done;
  logic clr_cnt = 1'b0;

  sweep_seq_ctrl #(
    .ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .addr_o(addr),
    .dac_start_o(dac_start), .dac_done_i(dac_done),
    .adc_start_o(adc_start), .adc_done_i(adc_done),
    .tx_start_o(tx_start),   .tx_done_i(tx_done),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] pulses();
    return 32'({dac_start, adc_start, tx_start, done});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counters and always-true properties, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr_cnt) begin
      cnt_dac = 0; cnt_adc = 0; cnt_tx = 0; cnt_done = 0;
    end else begin
      if (dac_start) cnt_dac++;
      if (adc_start) cnt_adc++;
      if (tx_start)  cnt_tx++;
      if (done)      cnt_done++;
    end
    chk("addr_range", 32'(addr <= ADDR_W'(LAST_ADDR)), 32'd1);
    chk("one_pulse", 32'($countones(pulses()) <= 1), 32'd1);
  end

  // Wait n cycles in a WAIT state, optionally firing stray handshakes.
  // kind: 0 = DAC_WAIT, 1 = ADC_WAIT, 2 = TX_WAIT.
  task automatic hold(input int kind, input int n, input int a, input bit spur);
    for (int i = 0; i < n; i++) begin
      chk("wait_quiet", pulses(), 32'd0);
      chk("wait_addr", 32'(addr), 32'(a));
      chk("wait_busy", 32'(busy), 32'd1);
      if (spur) begin
        start    = 1'($urandom_range(0, 1));
        dac_done = (kind != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        adc_done = (kind != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_done  = (kind != 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      tick();
      start = 1'b0; dac_done = 1'b0; adc_done = 1'b0; tx_done = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_pulses"}, pulses(), 32'd0);
  endtask

  // One address worth of handshakes, entered in the DAC_GO cycle.
  // mode: 0 normal, 1 abort in ADC_WAIT, 2 async reset in TX_WAIT,
  // 3 async reset during the dac_start pulse.
  task automatic run_sample(input int a, input bit spur, input int mode, output bit cut);
    int lo;
    cut = 1'b0;
    lo = spur ? 1 : 0;
    chk("dac_start", 32'(dac_start), 32'd1);
    chk("dac_addr", 32'(addr), 32'(a));
    chk("dac_busy", 32'(busy), 32'd1);
    chk("dac_only", 32'({adc_start, tx_start, done}), 32'd0);
    if (mode == 3) begin
      #2 rst_n = 1'b0;
      #1 check_idle("rst_dacgo");
      tick();
      rst_n = 1'b1;
      cut = 1'b1;
      return;
    end
    if (spur) dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
    hold(0, $urandom_range(lo, 3), a, spur);
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
    for (int i = 0; i < SETTLE_CYC; i++) begin
      chk("settle_quiet", pulses(), 32'd0);
      chk("settle_addr", 32'(addr), 32'(a));
      tick();
    end
    chk("adc_start", 32'(adc_start), 32'd1);
    chk("adc_addr", 32'(addr), 32'(a));
    tick();
    if (mode == 1) begin
      abort = 1'b1; adc_done = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; adc_done = 1'b0; start = 1'b0;
      check_idle("abort");
      tick();
      check_idle("abort_after");
      cut = 1'b1;
      return;
    end
    hold(1, $urandom_range(lo, 3), a, spur);
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    chk("tx_start", 32'(tx_start), 32'd1);
    chk("tx_addr", 32'(addr), 32'(a));
    tick();
    if (mode == 2) begin
      #2 rst_n = 1'b0;
      #1 check_idle("rst_txwait");
      tick();
      check_idle("rst_hold");
      rst_n = 1'b1;
      tick();
      check_idle("rst_release");
      cut = 1'b1;
      return;
    end
    hold(2, $urandom_range(lo, 3), a, spur);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("step_quiet", pulses(), 32'd0);
    chk("step_addr", 32'(addr), 32'(a));
    chk("step_busy", 32'(busy), 32'd1);
    tick();
  endtask

  // Full sweep; cut_at/mode select an address at which to abort or reset.
  task automatic run_sweep(input bit spur, input int cut_at, input int mode);
    bit cut;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check_idle("pre_start");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a <= LAST_ADDR; a++) begin
      run_sample(a, spur, (a == cut_at) ? mode : 0, cut);
      if (cut) begin
        chk("cut_no_done", 32'(cnt_done), 32'd0);
        return;
      end
    end
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_addr", 32'(addr), 32'(LAST_ADDR));
    chk("fin_busy", 32'(busy), 32'd1);
    tick();
    check_idle("post_fin");
    chk("n_dac", 32'(cnt_dac), 32'(LAST_ADDR + 1));
    chk("n_adc", 32'(cnt_adc), 32'(LAST_ADDR + 1));
    chk("n_tx", 32'(cnt_tx), 32'(LAST_ADDR + 1));
    chk("n_done", 32'(cnt_done), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    check_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_idle("idle");
    end
    run_sweep(1'b0, -1, 0);
    run_sweep(1'b1, -1, 0);
    run_sweep(1'b0, 2, 1);
    run_sweep(1'b0, -1, 0);
    run_sweep(1'b0, 1, 2);
    run_sweep(1'b1, -1, 0);
    run_sweep(1'b0, 0, 3);
    for (int r = 0; r < 8; r++) begin
      int m;
      m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_sweep(1'($urandom_range(0, 1)), $urandom_range(0, LAST_ADDR), m);
    end
    run_sweep(1'b1, -1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
